// File: rtl/powmod_if.sv
// Request/response handshake bundle for the powmod modular exponentiation unit.
// The requester drives X, E, req_valid and res_ready; the unit drives the rest.
interface powmod_if #(
  parameter int NBITS = 255
);
  logic [254:0]     X;
  logic [NBITS-1:0] E;
  logic [254:0]     Z;
  logic             req_valid;
  logic             req_ready;
  logic             req_busy;
  logic             res_valid;
  logic             res_ready;

  modport master (
    output X, E, req_valid, res_ready,
    input  Z, req_ready, req_busy, res_valid
  );

  modport slave (
    input  X, E, req_valid, res_ready,
    output Z, req_ready, req_busy, res_valid
  );
endinterface

// File: rtl/powmod.sv
// Z = X^E mod (2^255-19) by left-to-right square-and-multiply over one shared multiplier.
// Define POWMOD_SKIPZ_EN to skip leading zero exponent bits before any multiplier traffic.
module powmod_multmod (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [254:0] x,
  input  logic [254:0] y,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [254:0] z
);
  localparam logic [254:0] P25519 = {{247{1'b1}}, 8'hED};

  typedef enum logic [1:0] {M_IDLE, M_RUN, M_DONE} mstate_t;

  mstate_t      state_q, state_d;
  logic [254:0] a_q, a_d;
  logic [255:0] y_q, y_d;
  logic [254:0] acc_q, acc_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [319:0] step;

  // 2^255 == 19 (mod P): fold the high part twice, then one conditional subtract.
  function automatic logic [254:0] fold(input logic [319:0] v);
    logic [255:0] v1;
    logic [255:0] v2;
    v1 = {1'b0, v[254:0]} + 256'(v[319:255]) * 256'd19;
    v2 = {1'b0, v1[254:0]} + (v1[255] ? 256'd19 : 256'd0);
    if (v2 >= {1'b0, P25519}) v2 = v2 - {1'b0, P25519};
    return v2[254:0];
  endfunction

  // Consume the multiplier 64 bits per cycle, most significant digit first.
  assign step = {1'b0, acc_q, 64'd0} + 320'(a_q) * 320'(y_q[255:192]);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    a_d     = a_q;
    y_d     = y_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      M_IDLE: if (req_valid) begin
        a_d     = x;
        y_d     = {1'b0, y};
        acc_d   = '0;
        cnt_d   = '0;
        state_d = M_RUN;
      end
      M_RUN: begin
        acc_d = fold(step);
        y_d   = y_q << 64;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = M_DONE;
      end
      M_DONE: if (res_ready) state_d = M_IDLE;
      default: state_d = M_IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, so outputs are never X after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= M_IDLE;
      a_q     <= '0;
      y_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      a_q     <= a_d;
      y_q     <= y_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready = (state_q == M_IDLE);
  assign res_valid = (state_q == M_DONE);
  assign z         = acc_q;
endmodule

module powmod #(
  parameter int NBITS = 255
) (
  input  logic      clk,
  input  logic      rst,
  powmod_if.slave   bus
);
  localparam logic [254:0] P25519 = {{247{1'b1}}, 8'hED};
  localparam int IW = $clog2(NBITS);

  typedef enum logic [2:0] {
    IDLE, SQ_REQ, SQ_WAIT, MUL_REQ, MUL_WAIT, DONE
`ifdef POWMOD_SKIPZ_EN
    , SCAN
`endif
  } state_t;

  state_t           state_q, state_d, adv_state;
  logic [254:0]     xr_q, xr_d;
  logic [NBITS-1:0] er_q, er_d;
  logic [254:0]     acc_q, acc_d;
  logic [IW-1:0]    idx_q, idx_d, adv_idx;
  logic [254:0]     z_q, z_d;
  logic             res_valid_q, res_valid_d;
  logic             req_busy_q, req_busy_d;
  logic             mreq_valid_q, mreq_valid_d;
  logic             mres_ready_q, mres_ready_d;
  logic             req_ready;
  logic             m_req_ready, m_res_valid;
  logic [254:0]     m_y, m_z;

  assign req_ready = (state_q == IDLE) & ~rst;
  assign m_y       = (state_q == MUL_REQ) ? xr_q : acc_q;

  powmod_multmod u_mult (
    .clk       (clk),
    .rst       (rst),
    .req_valid (mreq_valid_q),
    .req_ready (m_req_ready),
    .x         (acc_q),
    .y         (m_y),
    .res_valid (m_res_valid),
    .res_ready (mres_ready_q),
    .z         (m_z)
  );

  always_comb begin
    state_d      = state_q;
    xr_d         = xr_q;
    er_d         = er_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    z_d          = z_q;
    mres_ready_d = mres_ready_q;
    adv_state    = (idx_q == '0) ? DONE : SQ_REQ;
    adv_idx      = (idx_q == '0) ? idx_q : idx_q - IW'(1);

    case (state_q)
      IDLE: if (bus.req_valid && req_ready) begin
        // X < 2^255 < 2P, so one subtract fully reduces the base.
        xr_d  = (bus.X >= P25519) ? bus.X - P25519 : bus.X;
        er_d  = bus.E;
        acc_d = 255'd1;
        idx_d = IW'(NBITS - 1);
`ifdef POWMOD_SKIPZ_EN
        state_d = SCAN;
`else
        state_d = SQ_REQ;
`endif
      end
`ifdef POWMOD_SKIPZ_EN
      SCAN: begin
        if (er_q == '0) begin
          acc_d   = 255'd1;
          state_d = DONE;
        end else if (er_q[idx_q]) begin
          // Squaring 1 and multiplying by Xr collapses to loading Xr.
          acc_d   = xr_q;
          state_d = adv_state;
          idx_d   = adv_idx;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
`endif
      SQ_REQ:  if (m_req_ready) state_d = SQ_WAIT;
      MUL_REQ: if (m_req_ready) state_d = MUL_WAIT;
      SQ_WAIT, MUL_WAIT: begin
        if (!mres_ready_q) begin
          if (m_res_valid) begin
            acc_d        = m_z;
            mres_ready_d = 1'b1;
          end
        end else if (!m_res_valid) begin
          mres_ready_d = 1'b0;
          if (state_q == SQ_WAIT && er_q[idx_q]) begin
            state_d = MUL_REQ;
          end else begin
            state_d = adv_state;
            idx_d   = adv_idx;
          end
        end
      end
      DONE: if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    mreq_valid_d = (state_d == SQ_REQ) || (state_d == MUL_REQ);
    res_valid_d  = (state_d == DONE);
    req_busy_d   = (state_d != IDLE) && (state_d != DONE);
    if (state_d == DONE && state_q != DONE) z_d = acc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      xr_q         <= '0;
      er_q         <= '0;
      acc_q        <= '0;
      idx_q        <= '0;
      z_q          <= '0;
      res_valid_q  <= 1'b0;
      req_busy_q   <= 1'b0;
      mreq_valid_q <= 1'b0;
      mres_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      xr_q         <= xr_d;
      er_q         <= er_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      z_q          <= z_d;
      res_valid_q  <= res_valid_d;
      req_busy_q   <= req_busy_d;
      mreq_valid_q <= mreq_valid_d;
      mres_ready_q <= mres_ready_d;
    end
  end

  assign bus.Z         = z_q;
  assign bus.res_valid = res_valid_q;
  assign bus.req_busy  = req_busy_q;
  assign bus.req_ready = req_ready;
endmodule

// File: tb/tb_powmod.sv
// Self-checking bench for powmod: vector table, handshake corner cases and random
// operands checked against a right-to-left exponentiation model.
module tb_powmod;
  localparam logic [254:0] P = {{247{1'b1}}, 8'hED};

  typedef struct {
    string        name;
    logic [254:0] x;
    logic [254:0] e;
    logic [254:0] z;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  powmod_if #(.NBITS(255)) bus ();

  powmod #(.NBITS(255)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [259:0] act, input logic [259:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timeout waiting for the DUT", name);
  endtask

  function automatic logic [254:0] dec(input string s);
    logic [259:0] v;
    v = '0;
    for (int i = 0; i < s.len(); i++) v = v * 260'd10 + 260'(s[i] - 8'd48);
    return v[254:0];
  endfunction

  // Right-to-left binary exponentiation on wide plain integers.
  function automatic logic [254:0] ref_pow(input logic [254:0] x, input logic [254:0] e);
    logic [511:0] r;
    logic [511:0] b;
    logic [511:0] m;
    m = 512'(P);
    r = 512'd1;
    b = 512'(x) % m;
    for (int i = 0; i < 255; i++) begin
      if (e[i]) r = (r * b) % m;
      b = (b * b) % m;
    end
    return r[254:0];
  endfunction

  function automatic logic [254:0] rand255();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t[254:0];
  endfunction

  task automatic send_req(input string name, input logic [254:0] x, input logic [254:0] e);
    bit ok;
    ok = 0;
    bus.X = x;
    bus.E = e;
    bus.req_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (bus.req_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) timeout({name, "_accept"});
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic get_res(input string name, input int hold, output logic [254:0] z);
    int c;
    c = 0;
    z = '0;
    while (!bus.res_valid && c < 20000) begin
      @(negedge clk);
      c++;
    end
    if (!bus.res_valid) begin
      timeout({name, "_result"});
      return;
    end
    z = bus.Z;
    check({name, "_busy_at_done"}, 260'(bus.req_busy), 260'd0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({name, "_hold"}, 260'({bus.res_valid, bus.req_ready, bus.Z}), 260'({1'b1, 1'b0, z}));
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check({name, "_release"}, 260'({bus.res_valid, bus.req_ready}), 260'(2'b01));
  endtask

  task automatic run_op(input string name, input logic [254:0] x, input logic [254:0] e,
                        input logic [254:0] exp, input int hold);
    logic [254:0] z;
    send_req(name, x, e);
    get_res(name, hold, z);
    check(name, 260'(z), 260'(exp));
  endtask

  initial begin
    vec_t         vecs[8];
    logic [254:0] x;
    logic [254:0] e;
    int           acc_n;
    int           got;

    checks   = 0;
    failures = 0;
    bus.X = '0;
    bus.E = '0;
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b0;

    vecs[0] = '{"fermat_inv2", 255'd2, P - 255'd2,
                dec("28948022309329048855892746252171976963317496166410141009864396001978282409975")};
    vecs[1] = '{"square",
                dec("3533012425803781230144052908719740726127014226477800802100354883158534798213"),
                255'd2,
                dec("41103782855417034832585754869730994192149373423248309125618910375726204070323")};
    vecs[2] = '{"e_zero",     255'd5,        255'd0, 255'd1};
    vecs[3] = '{"x_zero",     255'd0,        255'd5, 255'd0};
    vecs[4] = '{"x_p_plus_3", P + 255'd3,    255'd1, 255'd3};
    vecs[5] = '{"x_eq_p",     P,             255'd7, 255'd0};
    vecs[6] = '{"x0_e0",      255'd0,        255'd0, 255'd1};
    vecs[7] = '{"pm1_sq",     P - 255'd1,    255'd2, 255'd1};

    rst = 1'b0;
    #1 rst = 1'b1;
    #3;
    check("reset_outputs", 260'({bus.Z, bus.res_valid, bus.req_busy, bus.req_ready}), 260'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 260'(bus.req_ready), 260'd1);

    foreach (vecs[i]) run_op(vecs[i].name, vecs[i].x, vecs[i].e, vecs[i].z, 0);

    // Backpressure: result held for 20 cycles with res_ready low.
    x = rand255();
    e = rand255();
    run_op("backpressure", x, e, ref_pow(x, e), 20);

    // Asynchronous reset in the middle of the squaring chain.
    send_req("midreset", 255'd3, {1'b1, 254'd12345});
    repeat (40) @(negedge clk);
    check("midreset_busy_before", 260'(bus.req_busy), 260'd1);
    #2 rst = 1'b1;
    #1;
    check("midreset_outputs", 260'({bus.res_valid, bus.req_busy, bus.req_ready}), 260'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midreset_ready_after", 260'(bus.req_ready), 260'd1);
    run_op("after_reset_3pow3", 255'd3, 255'd3, 255'd27, 0);

    // Back-to-back requests with req_valid held and res_ready following res_valid.
    bus.X = 255'd2;
    bus.E = 255'd10;
    bus.req_valid = 1'b1;
    acc_n = 0;
    got = 0;
    for (int c = 0; c < 30000 && got < 2; c++) begin
      if (acc_n >= 2) bus.req_valid = 1'b0;
      if (bus.req_valid && bus.req_ready) acc_n++;
      bus.res_ready = bus.res_valid;
      if (bus.res_valid) begin
        got++;
        check("b2b_z", 260'(bus.Z), 260'd1024);
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b0;
    check("b2b_count", 260'(got), 260'd2);
    check("b2b_idle", 260'({bus.res_valid, bus.req_ready}), 260'(2'b01));

    // Random operands against the reference model.
    for (int r = 0; r < 6; r++) begin
      x = rand255();
      e = rand255();
      case (r)
        0: x = P + 255'($urandom_range(0, 18));
        1: e = 255'($urandom);
        3: e = 255'd1;
        4: e[254] = 1'b1;
        5: e = 255'($urandom_range(0, 3));
        default: ;
      endcase
      run_op($sformatf("random_%0d", r), x, e, ref_pow(x, e), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/powmod.md
Name: powmod

Overview:
- Modular exponentiation responder: computes Z = X^E mod P25519 (P = 2^255-19) by left-to-right square-and-multiply.
- Time-multiplexes a single internal multmod instance, acting as initiator on the multmod req/res handshake.
- Presents the same req/res handshake upstream as the other arithmetic units, so a top-level controller or field-inversion wrapper can drive it unchanged. The main client is Fermat inversion, X^(P-2).

Parameters:
- NBITS, 255, exponent width; the exponent scan starts at bit NBITS-1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- X  in  255  base; sampled on request acceptance
- E  in  NBITS  exponent; sampled on request acceptance
- Z  out  255  result, fully reduced to [0, P-1]
- req_valid  in  1  requester has a valid X/E
- req_ready  out  1  block can accept a request
- req_busy  out  1  computation in progress
- res_valid  out  1  Z is valid
- res_ready  in  1  requester has taken Z

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; Z=0; res_valid=0; req_busy=0.
  - req_ready = (state==IDLE) & !rst, so it is 0 while rst is high.
  - Internal multmod shares rst; a mid-operation reset abandons the computation with no partial result.
- States: IDLE, SQ_REQ, SQ_WAIT, MUL_REQ, MUL_WAIT, DONE.
- IDLE:
  - req_ready=1. The request is accepted on a cycle with req_valid & req_ready.
  - On accept: Xr = (X>=P) ? X-P : X (one conditional subtract is sufficient, since X < 2P); Er=E; acc=1; bit index i=NBITS-1.
  - Next state: SQ_REQ. req_busy=1 and req_ready=0 from the next cycle.
- SQ_REQ:
  - Drive multmod X=Y=acc with mult_req_valid=1.
  - On mult_req_valid & mult_req_ready, go to SQ_WAIT and drop mult_req_valid.
- SQ_WAIT:
  - When mult res_valid=1: capture acc, assert mult res_ready, and hold it until mult res_valid falls.
  - Then go to MUL_REQ if Er[i]=1, else advance.
- MUL_REQ / MUL_WAIT: same as SQ_REQ / SQ_WAIT, with operands acc and Xr; afterwards advance.
- Advance: if i==0, go to DONE; else i=i-1 and go to SQ_REQ.
- DONE:
  - Z=acc, res_valid=1, req_busy=0.
  - Z and res_valid are held stable until res_ready is sampled 1. The next cycle res_valid=0, state=IDLE, req_ready=1.
  - If req_valid is already high, a new request can be accepted on that IDLE cycle.
  - A res_ready that is already high when res_valid rises completes the transfer in one cycle.
- req_valid and res_ready are ignored outside IDLE and DONE respectively.
- Z changes only on entry to DONE.
- Latency: NBITS squarings plus popcount(E) multiplies, each costing multmod latency plus about 3 handshake cycles.
- Edge cases:
  - E=0 gives Z=1.
  - X=0 with E>0 gives Z=0.
  - X=0 with E=0 gives Z=1.
  - X=P gives Z=0 when E>0.

Optional Feature:
- Macro: POWMOD_SKIPZ_EN.
- Defined:
  - After accept, leading zero bits of Er are skipped at one bit per cycle (state SCAN) with no multmod traffic.
  - At the first 1 bit, acc is set to Xr directly (squaring and multiplying 1 is skipped) and the scan continues from i-1.
  - E=0 goes straight to DONE with Z=1, 2 cycles after accept.
- Undefined: every bit from NBITS-1 is processed as above.
- Results are identical either way; only latency differs.

Test Plan:
- Fermat inverse: X=2, E=P-2 -> Z=28948022309329048855892746252171976963317496166410141009864396001978282409975; res_valid=1 and req_busy=0 together.
- Square: X=3533012425803781230144052908719740726127014226477800802100354883158534798213, E=2 -> Z=41103782855417034832585754869730994192149373423248309125618910375726204070323.
- Edge cases:
  - X=5, E=0 -> Z=1.
  - X=0, E=5 -> Z=0.
  - X=2^255-16 (=P+3), E=1 -> Z=3.
- Backpressure: hold res_ready=0 for 20 cycles after res_valid -> Z and res_valid stay stable and req_ready stays 0. Raise res_ready -> res_valid=0 and req_ready=1 on the next cycle.
- Mid-operation reset: pulse rst asynchronously while in SQ_WAIT -> res_valid=0 and req_busy=0 immediately, req_ready=1 after rst falls. Then X=3, E=3 -> Z=27.
- Back-to-back requests: req_valid held at 1 with res_ready following res_valid -> two consecutive results with X=2, E=10 -> Z=1024 each time.
- Both runs: regressions are rerun with POWMOD_SKIPZ_EN defined and undefined, with identical Z required.
